// File: rtl/dcpu_alu_pkg.sv
// Shared types for the DCPU ALU sequencer: opcodes, ALU function codes,
// IF* condition kinds and sequencer FSM states.
package dcpu_alu_pkg;

    typedef enum logic [4:0] {
        OP_SET = 5'h01, OP_ADD = 5'h02, OP_SUB = 5'h03, OP_MUL = 5'h04,
        OP_MLI = 5'h05, OP_DIV = 5'h06, OP_DVI = 5'h07, OP_MOD = 5'h08,
        OP_MDI = 5'h09, OP_AND = 5'h0a, OP_BOR = 5'h0b, OP_XOR = 5'h0c,
        OP_SHR = 5'h0d, OP_ASR = 5'h0e, OP_SHL = 5'h0f, OP_IFB = 5'h10,
        OP_IFC = 5'h11, OP_IFE = 5'h12, OP_IFN = 5'h13, OP_IFG = 5'h14,
        OP_IFA = 5'h15, OP_IFL = 5'h16, OP_IFU = 5'h17, OP_ADX = 5'h1a,
        OP_SBX = 5'h1b
    } opcode_e;

    localparam logic [3:0] FN_ADD = 4'h0;
    localparam logic [3:0] FN_SUB = 4'h1;
    localparam logic [3:0] FN_ADX = 4'h2;
    localparam logic [3:0] FN_SBX = 4'h3;
    localparam logic [3:0] FN_MUL = 4'h4;
    localparam logic [3:0] FN_MLI = 4'h5;
    localparam logic [3:0] FN_DIV = 4'h6;
    localparam logic [3:0] FN_DVI = 4'h7;
    localparam logic [3:0] FN_MOD = 4'h8;
    localparam logic [3:0] FN_MDI = 4'h9;
    localparam logic [3:0] FN_AND = 4'ha;
    localparam logic [3:0] FN_BOR = 4'hb;
    localparam logic [3:0] FN_XOR = 4'hc;
    localparam logic [3:0] FN_SHR = 4'hd;
    localparam logic [3:0] FN_ASR = 4'he;
    localparam logic [3:0] FN_SHL = 4'hf;

    typedef enum logic [3:0] {
        COND_NONE = 4'd0, COND_B = 4'd1, COND_C = 4'd2, COND_E = 4'd3, COND_N = 4'd4,
        COND_G = 4'd5, COND_A = 4'd6, COND_L = 4'd7, COND_U = 4'd8
    } cond_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_DONE = 2'd2
    } state_e;

    // lt is the unsigned-less flag, un the signed-less flag.
    function automatic logic cond_true(cond_e c, logic cl, logic eq, logic lt, logic un);
        case (c)
            COND_B:  return !cl;
            COND_C:  return cl;
            COND_E:  return eq;
            COND_N:  return !eq;
            COND_G:  return !eq && !lt;
            COND_A:  return !eq && !un;
            COND_L:  return lt;
            COND_U:  return un;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dcpu_op_decode.sv
// Combinational opcode decoder: ALU function, latency class, writeback
// targets, IF* condition kind and the special-case flags the sequencer needs.
module dcpu_op_decode
    import dcpu_alu_pkg::*;
(
    input  logic [4:0] op,
    output logic [3:0] fn,
    output logic       muldiv,
    output logic       wb_b,
    output logic       wb_ex,
    output logic [3:0] cond,
    output logic       illegal,
    output logic       is_set,
    output logic       is_div,
    output logic       is_mod
);

    // opcode to control fields; anything not listed is undefined
    always_comb begin
        fn      = FN_ADD;
        muldiv  = 1'b0;
        wb_b    = 1'b0;
        wb_ex   = 1'b0;
        cond    = COND_NONE;
        illegal = 1'b0;
        is_set  = 1'b0;
        is_div  = 1'b0;
        is_mod  = 1'b0;
        case (op)
            OP_SET: begin wb_b = 1'b1; is_set = 1'b1; end
            OP_ADD: begin fn = FN_ADD; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_SUB: begin fn = FN_SUB; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_ADX: begin fn = FN_ADX; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_SBX: begin fn = FN_SBX; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_MUL: begin fn = FN_MUL; muldiv = 1'b1; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_MLI: begin fn = FN_MLI; muldiv = 1'b1; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_DIV: begin fn = FN_DIV; muldiv = 1'b1; wb_b = 1'b1; wb_ex = 1'b1; is_div = 1'b1; end
            OP_DVI: begin fn = FN_DVI; muldiv = 1'b1; wb_b = 1'b1; wb_ex = 1'b1; is_div = 1'b1; end
            OP_MOD: begin fn = FN_MOD; muldiv = 1'b1; wb_b = 1'b1; is_mod = 1'b1; end
            OP_MDI: begin fn = FN_MDI; muldiv = 1'b1; wb_b = 1'b1; is_mod = 1'b1; end
            OP_AND: begin fn = FN_AND; wb_b = 1'b1; end
            OP_BOR: begin fn = FN_BOR; wb_b = 1'b1; end
            OP_XOR: begin fn = FN_XOR; wb_b = 1'b1; end
            OP_SHR: begin fn = FN_SHR; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_ASR: begin fn = FN_ASR; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_SHL: begin fn = FN_SHL; wb_b = 1'b1; wb_ex = 1'b1; end
            OP_IFB: begin fn = FN_AND; cond = COND_B; end
            OP_IFC: begin fn = FN_AND; cond = COND_C; end
            OP_IFE: begin fn = FN_SUB; cond = COND_E; end
            OP_IFN: begin fn = FN_SUB; cond = COND_N; end
            OP_IFG: begin fn = FN_SUB; cond = COND_G; end
            OP_IFA: begin fn = FN_SUB; cond = COND_A; end
            OP_IFL: begin fn = FN_SUB; cond = COND_L; end
            OP_IFU: begin fn = FN_SUB; cond = COND_U; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dcpu_alu_sequencer.sv
// Issues one DCPU basic op at a time to the external ALU, holds operands for
// the class latency, captures the result and owns the architectural EX register.
module dcpu_alu_sequencer
    import dcpu_alu_pkg::*;
#(
    parameter int SIMPLE_CYCLES = 1,
    parameter int MULDIV_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [15:0] req_b,
    input  logic [15:0] req_a,
    output logic [3:0]  alu_fn,
    output logic [15:0] alu_b,
    output logic [15:0] alu_a,
    output logic [15:0] alu_exin,
    input  logic [15:0] alu_q,
    input  logic [15:0] alu_exout,
    input  logic        alu_cl,
    input  logic        alu_eq,
    input  logic        alu_lt,
    input  logic        alu_un,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_q,
    output logic        rsp_wb,
    output logic        rsp_skip,
    output logic        rsp_illegal,
    output logic [15:0] ex_q,
    input  logic        ex_wr,
    input  logic [15:0] ex_wdata
);

    localparam int MAX_LAT = (SIMPLE_CYCLES > MULDIV_CYCLES) ? SIMPLE_CYCLES : MULDIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    state_e             state_r, state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               req_ready_s, accept_s, capture_s;
    logic [3:0]         dec_fn_s, dec_cond_s;
    logic               dec_muldiv_s, dec_wb_b_s, dec_wb_ex_s, dec_illegal_s;
    logic               dec_set_s, dec_div_s, dec_mod_s;
    logic               wb_b_r, wb_ex_r, illegal_r, is_set_r, is_div_r, is_mod_r;
    cond_e              cond_r;
    logic [15:0]        cap_q_s, cap_ex_s;
    logic               cap_skip_s;

    dcpu_op_decode u_decode (
        .op      (req_op),
        .fn      (dec_fn_s),
        .muldiv  (dec_muldiv_s),
        .wb_b    (dec_wb_b_s),
        .wb_ex   (dec_wb_ex_s),
        .cond    (dec_cond_s),
        .illegal (dec_illegal_s),
        .is_set  (dec_set_s),
        .is_div  (dec_div_s),
        .is_mod  (dec_mod_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: if (req_valid) state_nxt_s = ST_EXEC; else state_nxt_s = ST_IDLE;
            ST_EXEC: if (cnt_r == CNT_W'(0)) state_nxt_s = ST_DONE; else state_nxt_s = ST_EXEC;
            ST_DONE: begin
                if (rsp_ready) begin
                    if (req_valid) state_nxt_s = ST_EXEC; else state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: ready, accept and capture strobes
    always_comb begin
        req_ready_s = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: req_ready_s = 1'b1;
            ST_EXEC: capture_s   = (cnt_r == CNT_W'(0));
            ST_DONE: req_ready_s = rsp_ready;
            default: req_ready_s = 1'b0;
        endcase
        accept_s = req_valid && req_ready_s;
    end

    assign req_ready = req_ready_s;
    assign alu_exin  = ex_q;

    // latency counter, loaded with LAT-1 on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_W'(0);
        end else if (accept_s) begin
            cnt_r <= dec_muldiv_s ? CNT_W'(MULDIV_CYCLES - 1) : CNT_W'(SIMPLE_CYCLES - 1);
        end else if ((state_r == ST_EXEC) && (cnt_r != CNT_W'(0))) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // operand/control latch, held stable from accept until capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_fn    <= FN_ADD;
            alu_b     <= 16'h0000;
            alu_a     <= 16'h0000;
            wb_b_r    <= 1'b0;
            wb_ex_r   <= 1'b0;
            cond_r    <= COND_NONE;
            illegal_r <= 1'b0;
            is_set_r  <= 1'b0;
            is_div_r  <= 1'b0;
            is_mod_r  <= 1'b0;
        end else if (accept_s) begin
            alu_fn    <= dec_fn_s;
            alu_b     <= req_b;
            alu_a     <= req_a;
            wb_b_r    <= dec_wb_b_s;
            wb_ex_r   <= dec_wb_ex_s;
            cond_r    <= cond_e'(dec_cond_s);
            illegal_r <= dec_illegal_s;
            is_set_r  <= dec_set_s;
            is_div_r  <= dec_div_s;
            is_mod_r  <= dec_mod_s;
        end else begin
            alu_fn    <= alu_fn;
            alu_b     <= alu_b;
            alu_a     <= alu_a;
            wb_b_r    <= wb_b_r;
            wb_ex_r   <= wb_ex_r;
            cond_r    <= cond_r;
            illegal_r <= illegal_r;
            is_set_r  <= is_set_r;
            is_div_r  <= is_div_r;
            is_mod_r  <= is_mod_r;
        end
    end

    // result selection; divide by zero overrides whatever the ALU produced
    always_comb begin
        cap_q_s    = alu_q;
        cap_ex_s   = alu_exout;
        cap_skip_s = 1'b0;
        if (illegal_r) begin
            cap_q_s = 16'h0000;
        end else if (is_set_r) begin
            cap_q_s = alu_a;
        end else if ((is_div_r || is_mod_r) && (alu_a == 16'h0000)) begin
            cap_q_s  = 16'h0000;
            cap_ex_s = 16'h0000;
        end else if (cond_r != COND_NONE) begin
            cap_skip_s = !cond_true(cond_r, alu_cl, alu_eq, alu_lt, alu_un);
        end else begin
            cap_q_s = alu_q;
        end
    end

    // response registers, held until the core accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid   <= 1'b0;
            rsp_q       <= 16'h0000;
            rsp_wb      <= 1'b0;
            rsp_skip    <= 1'b0;
            rsp_illegal <= 1'b0;
        end else if (capture_s) begin
            rsp_valid   <= 1'b1;
            rsp_q       <= cap_q_s;
            rsp_wb      <= wb_b_r;
            rsp_skip    <= cap_skip_s;
            rsp_illegal <= illegal_r;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid   <= 1'b0;
        end else begin
            rsp_valid   <= rsp_valid;
        end
    end

    // EX register: a capture write takes priority over a core write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= 16'h0000;
        end else if (capture_s && wb_ex_r) begin
            ex_q <= cap_ex_s;
        end else if (ex_wr) begin
            ex_q <= ex_wdata;
        end else begin
            ex_q <= ex_q;
        end
    end

endmodule

// File: tb/tb_dcpu_alu_sequencer.sv
// Self-checking bench for dcpu_alu_sequencer: directed vector table, hand-written
// handshake/reset sequences and randomized ops against a DCPU reference model.
module tb_dcpu_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [4:0]  req_op;
    logic [15:0] req_b, req_a;
    logic [3:0]  alu_fn;
    logic [15:0] alu_b, alu_a, alu_exin, alu_q, alu_exout;
    logic        alu_cl, alu_eq, alu_lt, alu_un;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_q;
    logic        rsp_wb, rsp_skip, rsp_illegal;
    logic [15:0] ex_q;
    logic        ex_wr;
    logic [15:0] ex_wdata;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] q;
        logic        wb;
        logic        skip;
        logic        ill;
        logic [15:0] ex;
        int          lat;
    } res_t;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] b;
        logic [15:0] a;
        logic [15:0] q;
        logic        wb;
        logic        skip;
        logic        ill;
        logic [15:0] ex;
        int          lat;
    } vec_t;

    dcpu_alu_sequencer #(.SIMPLE_CYCLES(1), .MULDIV_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_b(req_b), .req_a(req_a),
        .alu_fn(alu_fn), .alu_b(alu_b), .alu_a(alu_a), .alu_exin(alu_exin),
        .alu_q(alu_q), .alu_exout(alu_exout),
        .alu_cl(alu_cl), .alu_eq(alu_eq), .alu_lt(alu_lt), .alu_un(alu_un),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q),
        .rsp_wb(rsp_wb), .rsp_skip(rsp_skip), .rsp_illegal(rsp_illegal),
        .ex_q(ex_q), .ex_wr(ex_wr), .ex_wdata(ex_wdata)
    );

    always #5 clk = ~clk;

    // Environment ALU: DCPU arithmetic keyed on fn; divide by zero yields junk.
    function automatic logic [31:0] alu_model(logic [3:0] fn, logic [15:0] b, logic [15:0] a, logic [15:0] x);
        longint t, u;
        logic [15:0] q, e;
        q = 16'h0000;
        e = x;
        t = 64'sd0;
        u = 64'sd0;
        case (fn)
            4'h0: begin t = longint'(b) + longint'(a); q = t[15:0]; e = t[16] ? 16'h0001 : 16'h0000; end
            4'h1: begin t = longint'(b) - longint'(a); q = t[15:0]; e = (t < 0) ? 16'hFFFF : 16'h0000; end
            4'h2: begin t = longint'(b) + longint'(a) + longint'(x); q = t[15:0]; e = (t > 65535) ? 16'h0001 : 16'h0000; end
            4'h3: begin
                t = longint'(b) - longint'(a) + longint'(x); q = t[15:0];
                e = (t < 0) ? 16'hFFFF : ((t > 65535) ? 16'h0001 : 16'h0000);
            end
            4'h4: begin t = longint'(b) * longint'(a); q = t[15:0]; e = t[31:16]; end
            4'h5: begin t = longint'($signed(b)) * longint'($signed(a)); q = t[15:0]; e = t[31:16]; end
            4'h6: begin
                if (a == 16'h0000) begin q = 16'hDEAD; e = 16'hDEAD; end
                else begin t = longint'(b) / longint'(a); u = (longint'(b) << 16) / longint'(a); q = t[15:0]; e = u[15:0]; end
            end
            4'h7: begin
                if (a == 16'h0000) begin q = 16'hDEAD; e = 16'hDEAD; end
                else begin
                    t = longint'($signed(b)) / longint'($signed(a));
                    u = (longint'($signed(b)) * 65536) / longint'($signed(a));
                    q = t[15:0]; e = u[15:0];
                end
            end
            4'h8: begin if (a == 16'h0000) q = 16'hDEAD; else q = b % a; end
            4'h9: begin
                if (a == 16'h0000) q = 16'hDEAD;
                else begin t = longint'($signed(b)) % longint'($signed(a)); q = t[15:0]; end
            end
            4'ha: q = b & a;
            4'hb: q = b | a;
            4'hc: q = b ^ a;
            4'hd: begin t = (longint'(b) << 16) >> a; q = t[31:16]; e = t[15:0]; end
            4'he: begin t = (longint'($signed(b)) * 65536) >>> a; q = t[31:16]; e = t[15:0]; end
            default: begin t = longint'(b) << a; q = t[15:0]; e = t[31:16]; end
        endcase
        return {q, e};
    endfunction

    always_comb begin
        {alu_q, alu_exout} = alu_model(alu_fn, alu_b, alu_a, alu_exin);
        alu_cl = ((alu_b & alu_a) == 16'h0000);
        alu_eq = (alu_b == alu_a);
        alu_lt = (alu_b < alu_a);
        alu_un = ($signed(alu_b) < $signed(alu_a));
    end

    // Reference: architectural effect of one DCPU op, by opcode number.
    function automatic res_t ref_op(logic [4:0] op, logic [15:0] b, logic [15:0] a, logic [15:0] ex);
        res_t r;
        int ub, ua, sb, sa;
        longint w;
        logic [15:0] lo, hi;
        ub = int'(b); ua = int'(a); sb = int'($signed(b)); sa = int'($signed(a));
        r.q = 16'h0000; r.wb = 1'b0; r.skip = 1'b0; r.ill = 1'b0; r.ex = ex;
        r.lat = (op >= 5'h04 && op <= 5'h09) ? 3 : 1;
        if (op >= 5'h01 && op <= 5'h0f) r.wb = 1'b1;
        if (op == 5'h1a || op == 5'h1b) r.wb = 1'b1;
        w = 64'sd0;
        case (op)
            5'h01: r.q = a;
            5'h02: begin w = ub + ua; lo = w[15:0]; r.q = lo; r.ex = (w >= 65536) ? 16'h0001 : 16'h0000; end
            5'h03: begin w = ub - ua; lo = w[15:0]; r.q = lo; r.ex = (ub < ua) ? 16'hFFFF : 16'h0000; end
            5'h1a: begin w = ub + ua + int'(ex); lo = w[15:0]; r.q = lo; r.ex = (w >= 65536) ? 16'h0001 : 16'h0000; end
            5'h1b: begin
                w = ub - ua + int'(ex); lo = w[15:0]; r.q = lo;
                r.ex = (w < 0) ? 16'hFFFF : ((w >= 65536) ? 16'h0001 : 16'h0000);
            end
            5'h04: begin w = longint'(ub) * ua; lo = w[15:0]; hi = w[31:16]; r.q = lo; r.ex = hi; end
            5'h05: begin w = longint'(sb) * sa; lo = w[15:0]; hi = w[31:16]; r.q = lo; r.ex = hi; end
            5'h06: begin
                if (a == 16'h0000) begin r.q = 16'h0000; r.ex = 16'h0000; end
                else begin w = ub / ua; lo = w[15:0]; r.q = lo; w = (longint'(ub) * 65536) / ua; lo = w[15:0]; r.ex = lo; end
            end
            5'h07: begin
                if (a == 16'h0000) begin r.q = 16'h0000; r.ex = 16'h0000; end
                else begin w = sb / sa; lo = w[15:0]; r.q = lo; w = (longint'(sb) * 65536) / sa; lo = w[15:0]; r.ex = lo; end
            end
            5'h08: begin if (a == 16'h0000) r.q = 16'h0000; else begin w = ub % ua; lo = w[15:0]; r.q = lo; end end
            5'h09: begin if (a == 16'h0000) r.q = 16'h0000; else begin w = sb % sa; lo = w[15:0]; r.q = lo; end end
            5'h0a: r.q = b & a;
            5'h0b: r.q = b | a;
            5'h0c: r.q = b ^ a;
            5'h0d: begin w = (longint'(ub) * 65536) >> ua; lo = w[15:0]; hi = w[31:16]; r.q = hi; r.ex = lo; end
            5'h0e: begin w = (longint'(sb) * 65536) >>> ua; lo = w[15:0]; hi = w[31:16]; r.q = hi; r.ex = lo; end
            5'h0f: begin w = longint'(ub) << ua; lo = w[15:0]; hi = w[31:16]; r.q = lo; r.ex = hi; end
            5'h10: r.skip = !((b & a) != 16'h0000);
            5'h11: r.skip = !((b & a) == 16'h0000);
            5'h12: r.skip = !(ub == ua);
            5'h13: r.skip = !(ub != ua);
            5'h14: r.skip = !(ub > ua);
            5'h15: r.skip = !(sb > sa);
            5'h16: r.skip = !(ub < ua);
            5'h17: r.skip = !(sb < sa);
            default: r.ill = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Issue one op with rsp_ready high, measure latency, sample result, drain.
    task automatic run_op(input logic [4:0] op, input logic [15:0] b, input logic [15:0] a, output res_t r);
        int n;
        @(negedge clk);
        req_op = op; req_b = b; req_a = a; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        r.lat = 0;
        while (!rsp_valid && r.lat < 50) begin @(posedge clk); #1; r.lat++; end
        r.q = rsp_q; r.wb = rsp_wb; r.skip = rsp_skip; r.ill = rsp_illegal; r.ex = ex_q;
        @(posedge clk); #1;
    endtask

    task automatic compare(input string tag, input res_t act, input res_t exp);
        if (exp.wb) check({tag, ".q"}, 32'(act.q), 32'(exp.q));
        check({tag, ".wb"},   32'(act.wb),   32'(exp.wb));
        check({tag, ".skip"}, 32'(act.skip), 32'(exp.skip));
        check({tag, ".ill"},  32'(act.ill),  32'(exp.ill));
        check({tag, ".ex"},   32'(act.ex),   32'(exp.ex));
        check({tag, ".lat"},  32'(act.lat),  32'(exp.lat));
    endtask

    vec_t vecs[21];
    res_t got, exp_r;
    logic [15:0] ex_model;
    int bad;

    initial begin
        vecs[0]  = '{5'h02, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1};
        vecs[1]  = '{5'h1a, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 1};
        vecs[2]  = '{5'h04, 16'h1234, 16'h0100, 16'h3400, 1'b1, 1'b0, 1'b0, 16'h0012, 3};
        vecs[3]  = '{5'h06, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 3};
        vecs[4]  = '{5'h03, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1};
        vecs[5]  = '{5'h08, 16'h0007, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'hFFFF, 3};
        vecs[6]  = '{5'h14, 16'h0005, 16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1};
        vecs[7]  = '{5'h14, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1};
        vecs[8]  = '{5'h10, 16'h00F0, 16'h000F, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1};
        vecs[9]  = '{5'h17, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1};
        vecs[10] = '{5'h18, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1};
        vecs[11] = '{5'h01, 16'h1234, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1};
        vecs[12] = '{5'h15, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1};
        vecs[13] = '{5'h16, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1};
        vecs[14] = '{5'h11, 16'h00F0, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 16'hFFFF, 1};
        vecs[15] = '{5'h06, 16'h0007, 16'h0002, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h8000, 3};
        vecs[16] = '{5'h0f, 16'h8001, 16'h0004, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0008, 1};
        vecs[17] = '{5'h0c, 16'h00FF, 16'h0F0F, 16'h0FF0, 1'b1, 1'b0, 1'b0, 16'h0008, 1};
        vecs[18] = '{5'h09, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0008, 3};
        vecs[19] = '{5'h1f, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0008, 1};
        vecs[20] = '{5'h07, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b1, 1'b0, 1'b0, 16'h8000, 3};

        rst_n = 1'b0; req_valid = 1'b0; req_op = 5'h00; req_b = 16'h0000; req_a = 16'h0000;
        rsp_ready = 1'b1; ex_wr = 1'b0; ex_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.ex_q",      32'(ex_q),      32'd0);
        check("reset.rsp_q",     32'(rsp_q),     32'd0);
        check("reset.alu_b",     32'(alu_b),     32'd0);

        for (int i = 0; i < 21; i++) begin
            exp_r = '{vecs[i].q, vecs[i].wb, vecs[i].skip, vecs[i].ill, vecs[i].ex, vecs[i].lat};
            run_op(vecs[i].op, vecs[i].b, vecs[i].a, got);
            compare($sformatf("vec%0d", i), got, exp_r);
        end

        // back-to-back issue: second ADD accepted on the edge the first response leaves
        @(negedge clk);
        req_op = 5'h02; req_b = 16'h0001; req_a = 16'h0001; req_valid = 1'b1;
        @(posedge clk); #1;
        req_b = 16'h0002; req_a = 16'h0002;
        @(posedge clk); #1;
        check("b2b.first_valid", 32'(rsp_valid), 32'd1);
        check("b2b.first_q",     32'(rsp_q),     32'h2);
        check("b2b.ready",       32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("b2b.gap_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("b2b.second_valid", 32'(rsp_valid), 32'd1);
        check("b2b.second_q",     32'(rsp_q),     32'h4);
        @(posedge clk); #1;

        // backpressure: response held, no new accept while stalled
        @(negedge clk);
        rsp_ready = 1'b0;
        req_op = 5'h02; req_b = 16'h0001; req_a = 16'h0002; req_valid = 1'b1;
        @(posedge clk); #1;
        req_op = 5'h03; req_b = 16'h0100; req_a = 16'h0050;
        @(posedge clk); #1;
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!(rsp_valid && rsp_q == 16'h0003 && rsp_wb && !rsp_skip && !req_ready)) bad++;
        end
        check("stall.stable_cycles_bad", 32'(bad), 32'd0);
        check("stall.rsp_q", 32'(rsp_q), 32'h0003);
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall.released", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("stall.no_extra_rsp", 32'(rsp_valid), 32'd0);

        // ex_wr on the ADD capture edge loses to the ALU EX
        @(negedge clk);
        req_op = 5'h02; req_b = 16'hFFFF; req_a = 16'h0002; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; ex_wr = 1'b1; ex_wdata = 16'h5555;
        @(posedge clk); #1;
        ex_wr = 1'b0;
        check("exwr_collide.rsp_q", 32'(rsp_q), 32'h0001);
        check("exwr_collide.ex_q",  32'(ex_q),  32'h0001);
        @(posedge clk); #1;
        @(negedge clk);
        ex_wr = 1'b1; ex_wdata = 16'h5555;
        @(posedge clk); #1;
        ex_wr = 1'b0;
        check("exwr_idle.ex_q", 32'(ex_q), 32'h5555);
        run_op(5'h1a, 16'h0000, 16'h0000, got);
        compare("adx_after_exwr", got, '{16'h5555, 1'b1, 1'b0, 1'b0, 16'h0000, 1});

        // reset in the middle of a MUL
        @(negedge clk);
        ex_wr = 1'b1; ex_wdata = 16'h7777;
        @(negedge clk);
        ex_wr = 1'b0;
        req_op = 5'h04; req_b = 16'h1234; req_a = 16'h0100; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset.ex_q",      32'(ex_q),      32'd0);
        check("midreset.rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) bad++;
        end
        check("midreset.quiet_cycles_bad", 32'(bad), 32'd0);
        check("midreset.ex_after", 32'(ex_q), 32'd0);

        // randomized ops against the reference model
        ex_model = 16'h0000;
        for (int i = 0; i < 200; i++) begin
            logic [4:0]  op;
            logic [15:0] b, a;
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                ex_wr = 1'b1; ex_wdata = 16'($urandom);
                ex_model = ex_wdata;
                @(posedge clk); #1;
                ex_wr = 1'b0;
            end
            op = 5'($urandom_range(0, 31));
            b  = 16'($urandom);
            if (op >= 5'h0d && op <= 5'h0f) a = 16'($urandom_range(0, 20));
            else if ($urandom_range(0, 7) == 0) a = 16'h0000;
            else a = 16'($urandom);
            exp_r = ref_op(op, b, a, ex_model);
            run_op(op, b, a, got);
            compare($sformatf("rnd%0d_op%0h_b%0h_a%0h", i, op, b, a), got, exp_r);
            ex_model = exp_r.ex;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
